// File: rtl/rcg_ctrl_div_seq.sv
// ---------------------------------------------------------------------------
// rcg_ctrl_div_seq : ratio-change sequencer (align -> hold reset -> go pulse)
// Optional alignment timeout: define RCG_DIV_SEQ_TIMEOUT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rcg_ctrl_div_seq #(
    parameter int DIV_WIDTH   = 16,
    parameter int NUM_DIV     = 4,
    parameter int ALN_HOLD    = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           clk_in,
    input  logic                           grst,
    input  logic                           req_vld,
    input  logic [NUM_DIV*DIV_WIDTH-1:0]   req_ratio,
    output logic                           req_rdy,
    input  logic [NUM_DIV-1:0]             div_clk_align,
    output logic [NUM_DIV*DIV_WIDTH-1:0]   div_ratio,
    output logic                           div_aln_rst_n,
    output logic                           divider_go_pls,
    output logic                           seq_busy,
    output logic                           seq_done,
    output logic                           aln_err
);

    localparam int                   RW        = NUM_DIV * DIV_WIDTH;
    localparam logic [7:0]           HOLD_LAST = 8'(ALN_HOLD - 1);
    localparam logic [DIV_WIDTH-1:0] ONE_F     = DIV_WIDTH'(1);
    localparam logic [RW-1:0]        ONES      = {NUM_DIV{ONE_F}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ALN = 2'd1,
        S_HOLD     = 2'd2,
        S_GO       = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   lat_q, lat_d;
    logic [RW-1:0]   ratio_q, ratio_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic            rdy_q, aln_rst_n_q, go_q, busy_q, done_q;
    logic            w_all_aln;
    logic            w_timeout;

    assign w_all_aln = &div_clk_align;

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        ratio_d    = ratio_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_vld) begin
                    lat_d   = req_ratio;
                    state_d = S_WAIT_ALN;
                end
            end
            S_WAIT_ALN: begin
                // The only place the divider ratios are allowed to move.
                if (w_all_aln || w_timeout) begin
                    ratio_d    = lat_q;
                    hold_cnt_d = '0;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = S_GO;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            S_GO:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk_in) begin
        if (grst) begin
            state_q     <= S_IDLE;
            lat_q       <= ONES;
            ratio_q     <= ONES;
            hold_cnt_q  <= '0;
            rdy_q       <= 1'b1;
            aln_rst_n_q <= 1'b1;
            go_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            ratio_q     <= ratio_d;
            hold_cnt_q  <= hold_cnt_d;
            rdy_q       <= (state_d == S_IDLE);
            aln_rst_n_q <= (state_d != S_HOLD);
            go_q        <= (state_d == S_GO);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_q == S_GO);
        end
    end

`ifdef RCG_DIV_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        aln_err_q, aln_err_d;

    assign w_timeout = (state_q == S_WAIT_ALN) && (wait_cnt_q == TO_LAST);

    // Counter rests at zero outside WAIT_ALN, so every entry starts fresh.
    always_comb begin
        wait_cnt_d = '0;
        aln_err_d  = aln_err_q;
        if (state_q == S_WAIT_ALN) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
        if (state_q == S_IDLE && req_vld) begin
            aln_err_d = 1'b0;
        end else if (w_timeout && !w_all_aln) begin
            aln_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (grst) begin
            wait_cnt_q <= '0;
            aln_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            aln_err_q  <= aln_err_d;
        end
    end

    assign aln_err = aln_err_q;
`else
    assign w_timeout = 1'b0;
    assign aln_err   = 1'b0;
`endif

    assign req_rdy        = rdy_q;
    assign div_ratio      = ratio_q;
    assign div_aln_rst_n  = aln_rst_n_q;
    assign divider_go_pls = go_q;
    assign seq_busy       = busy_q;
    assign seq_done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rcg_ctrl_div_seq.sv
// ---------------------------------------------------------------------------
// tb_rcg_ctrl_div_seq : scenario bench for the ratio-change sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rcg_ctrl_div_seq;

    localparam int DW  = 16;
    localparam int ND  = 4;
    localparam int RW  = DW * ND;
    localparam int AH  = 4;
    localparam int TOC = 16;
    localparam logic [RW-1:0] ONES = {16'd1, 16'd1, 16'd1, 16'd1};

    logic            clk_in = 1'b0;
    logic            grst;
    logic            req_vld;
    logic [RW-1:0]   req_ratio;
    logic            req_rdy;
    logic [ND-1:0]   div_clk_align;
    logic [RW-1:0]   div_ratio;
    logic            div_aln_rst_n;
    logic            divider_go_pls;
    logic            seq_busy;
    logic            seq_done;
    logic            aln_err;

    int errors = 0;
    int checks = 0;

    logic [RW-1:0] sb[$];
    logic [RW-1:0] mon_prev_ratio;
    logic          mon_prev_rst_n;
    logic          mon_rst;
    logic [RW-1:0] mon_exp;

    always #5 clk_in = ~clk_in;

    rcg_ctrl_div_seq #(
        .DIV_WIDTH   (DW),
        .NUM_DIV     (ND),
        .ALN_HOLD    (AH),
        .TIMEOUT_CYC (TOC)
    ) dut (
        .clk_in         (clk_in),
        .grst           (grst),
        .req_vld        (req_vld),
        .req_ratio      (req_ratio),
        .req_rdy        (req_rdy),
        .div_clk_align  (div_clk_align),
        .div_ratio      (div_ratio),
        .div_aln_rst_n  (div_aln_rst_n),
        .divider_go_pls (divider_go_pls),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .aln_err        (aln_err)
    );

    // Ratio monitor: pops the scoreboard on each HOLD entry; any other ratio
    // movement must be a reset back to all ones.
    always @(posedge clk_in) begin
        mon_rst        = grst;
        mon_prev_ratio = div_ratio;
        mon_prev_rst_n = div_aln_rst_n;
        #2;
        if (!mon_rst && mon_prev_rst_n === 1'b1 && div_aln_rst_n === 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_pop: HOLD entered with ratio %h but no request pending", div_ratio);
            end else begin
                mon_exp = sb.pop_front();
                if (div_ratio !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_ratio: got %h exp %h", div_ratio, mon_exp);
                end
            end
        end else if (div_ratio !== mon_prev_ratio) begin
            checks++;
            if (!mon_rst) begin
                errors++;
                $display("FAIL ratio_stable: changed %h -> %h outside HOLD entry", mon_prev_ratio, div_ratio);
            end else if (div_ratio !== ONES) begin
                errors++;
                $display("FAIL ratio_reset: got %h exp %h", div_ratio, ONES);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic accept(input logic [RW-1:0] r);
        req_vld   = 1'b1;
        req_ratio = r;
        sb.push_back(r);
        tick();
        req_vld = 1'b0;
        checks++;
        if (req_rdy !== 1'b0 || seq_busy !== 1'b1 || seq_done !== 1'b0 || div_aln_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL accept: rdy=%b busy=%b done=%b rst_n=%b exp 0 1 0 1",
                     req_rdy, seq_busy, seq_done, div_aln_rst_n);
        end
    endtask

    // Called in the first HOLD cycle; returns in the seq_done cycle.
    task automatic finish_seq(input logic [RW-1:0] r);
        for (int k = 1; k < AH; k++) begin
            tick();
            checks++;
            if (div_aln_rst_n !== 1'b0 || divider_go_pls !== 1'b0 || div_ratio !== r) begin
                errors++;
                $display("FAIL hold_%0d: rst_n=%b go=%b ratio=%h exp 0 0 %h",
                         k, div_aln_rst_n, divider_go_pls, div_ratio, r);
            end
        end
        tick();
        checks++;
        if (divider_go_pls !== 1'b1 || div_aln_rst_n !== 1'b1 || seq_busy !== 1'b1 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL go: go=%b rst_n=%b busy=%b done=%b exp 1 1 1 0",
                     divider_go_pls, div_aln_rst_n, seq_busy, seq_done);
        end
        tick();
        checks++;
        if (seq_done !== 1'b1 || divider_go_pls !== 1'b0 || req_rdy !== 1'b1 || seq_busy !== 1'b0) begin
            errors++;
            $display("FAIL done: done=%b go=%b rdy=%b busy=%b exp 1 0 1 0",
                     seq_done, divider_go_pls, req_rdy, seq_busy);
        end
    endtask

    task automatic test_reset();
        grst = 1'b1;
        tick();
        tick();
        checks++;
        if (req_rdy !== 1'b1 || div_ratio !== ONES || div_aln_rst_n !== 1'b1 || divider_go_pls !== 1'b0 ||
            seq_busy !== 1'b0 || seq_done !== 1'b0 || aln_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b ratio=%h rst_n=%b go=%b busy=%b done=%b err=%b exp 1 %h 1 0 0 0 0",
                     req_rdy, div_ratio, div_aln_rst_n, divider_go_pls, seq_busy, seq_done, aln_err, ONES);
        end
        grst = 1'b0;
    endtask

    task automatic hold_entry(input string nm, input logic [RW-1:0] r);
        tick();
        checks++;
        if (div_aln_rst_n !== 1'b0 || div_ratio !== r || divider_go_pls !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold_entry: rst_n=%b ratio=%h go=%b exp 0 %h 0",
                     nm, div_aln_rst_n, div_ratio, divider_go_pls, r);
        end
    endtask

    task automatic test_basic();
        logic [RW-1:0] r = {16'd2, 16'd4, 16'd8, 16'd3};
        div_clk_align = 4'hF;
        accept(r);
        hold_entry("basic", r);
        finish_seq(r);
    endtask

    task automatic test_stagger();
        logic [RW-1:0] r_old = {16'd2, 16'd4, 16'd8, 16'd3};
        logic [RW-1:0] r     = {16'd5, 16'd6, 16'd7, 16'd9};
        div_clk_align = 4'h0;
        accept(r);
        for (int i = 0; i < 50; i++) begin
            div_clk_align = 4'b0001 << (i % 4);
            tick();
            checks++;
            if (div_aln_rst_n !== 1'b1 || div_ratio !== r_old) begin
                errors++;
                $display("FAIL stagger_%0d: rst_n=%b ratio=%h exp 1 %h", i, div_aln_rst_n, div_ratio, r_old);
            end
        end
        div_clk_align = 4'hF;
        hold_entry("stagger", r);
        finish_seq(r);
    endtask

    task automatic test_ignore_in_hold();
        logic [RW-1:0] r  = {16'd10, 16'd11, 16'd12, 16'd13};
        logic [RW-1:0] r2 = {16'd20, 16'd21, 16'd22, 16'd23};
        div_clk_align = 4'hF;
        accept(r);
        hold_entry("ignore", r);
        req_vld   = 1'b1;
        req_ratio = r2;
        for (int k = 1; k < AH; k++) begin
            tick();
            checks++;
            if (req_rdy !== 1'b0 || div_aln_rst_n !== 1'b0) begin
                errors++;
                $display("FAIL ignore_hold_%0d: rdy=%b rst_n=%b exp 0 0", k, req_rdy, div_aln_rst_n);
            end
        end
        tick();
        checks++;
        if (divider_go_pls !== 1'b1 || req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_go: go=%b rdy=%b exp 1 0", divider_go_pls, req_rdy);
        end
        req_vld = 1'b0;
        tick();
        checks++;
        if (seq_done !== 1'b1 || div_ratio !== r) begin
            errors++;
            $display("FAIL ignore_done: done=%b ratio=%h exp 1 %h", seq_done, div_ratio, r);
        end
        tick();
        checks++;
        if (seq_busy !== 1'b0 || req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_idle: busy=%b rdy=%b exp 0 1", seq_busy, req_rdy);
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] ra = {16'd0, 16'd1, 16'hFFFF, 16'd1};
        logic [RW-1:0] rb = {16'd1, 16'd0, 16'd3, 16'h8000};
        div_clk_align = 4'hF;
        accept(ra);
        hold_entry("b2b_a", ra);
        finish_seq(ra);
        accept(rb);
        hold_entry("b2b_b", rb);
        finish_seq(rb);
    endtask

    task automatic test_reset_in_hold();
        logic [RW-1:0] r = {16'd30, 16'd31, 16'd32, 16'd33};
        div_clk_align = 4'hF;
        accept(r);
        hold_entry("rst", r);
        tick();
        grst = 1'b1;
        tick();
        grst = 1'b0;
        checks++;
        if (div_aln_rst_n !== 1'b1 || div_ratio !== ONES || divider_go_pls !== 1'b0 ||
            req_rdy !== 1'b1 || seq_busy !== 1'b0 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold: rst_n=%b ratio=%h go=%b rdy=%b busy=%b done=%b exp 1 %h 0 1 0 0",
                     div_aln_rst_n, div_ratio, divider_go_pls, req_rdy, seq_busy, seq_done, ONES);
        end
        div_clk_align = 4'h0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (divider_go_pls !== 1'b0 || seq_done !== 1'b0 || seq_busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_after_%0d: go=%b done=%b busy=%b exp 0 0 0",
                         i, divider_go_pls, seq_done, seq_busy);
            end
        end
    endtask

`ifdef RCG_DIV_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [RW-1:0] r  = {16'd40, 16'd41, 16'd42, 16'd43};
        logic [RW-1:0] r2 = {16'd50, 16'd51, 16'd52, 16'd53};
        div_clk_align = 4'h0;
        accept(r);
        for (int i = 1; i < TOC; i++) begin
            tick();
            checks++;
            if (div_aln_rst_n !== 1'b1 || aln_err !== 1'b0) begin
                errors++;
                $display("FAIL to_wait_%0d: rst_n=%b err=%b exp 1 0", i, div_aln_rst_n, aln_err);
            end
        end
        tick();
        checks++;
        if (div_aln_rst_n !== 1'b0 || aln_err !== 1'b1 || div_ratio !== r) begin
            errors++;
            $display("FAIL to_fire: rst_n=%b err=%b ratio=%h exp 0 1 %h", div_aln_rst_n, aln_err, div_ratio, r);
        end
        finish_seq(r);
        checks++;
        if (aln_err !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: err=%b exp 1", aln_err);
        end
        div_clk_align = 4'hF;
        accept(r2);
        checks++;
        if (aln_err !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: err=%b exp 0", aln_err);
        end
        hold_entry("to_next", r2);
        finish_seq(r2);
    endtask
`endif

    initial begin
        grst          = 1'b1;
        req_vld       = 1'b0;
        req_ratio     = '0;
        div_clk_align = 4'h0;
        test_reset();
        test_basic();
        test_stagger();
        test_ignore_in_hold();
        test_back_to_back();
        test_reset_in_hold();
`ifdef RCG_DIV_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_empty: %0d expected ratios never applied, exp 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rcg_ctrl_div_seq.md
RCG_CTRL_DIV_SEQ -- requirements
Module: rcg_ctrl_div_seq

Interface
REQ-001 Parameter DIV_WIDTH, default 16, width of each divider ratio.
REQ-002 Parameter NUM_DIV, default 4, number of divider counters driven in lockstep.
REQ-003 Parameter ALN_HOLD, default 4, number of cycles div_aln_rst_n is held low; legal range 1..255.
REQ-004 Parameter TIMEOUT_CYC, default 1024, alignment wait limit in cycles; legal range 1..65535.
REQ-005 clk_in  input  1  single functional clock; all logic on its rising edge.
REQ-006 grst  input  1  synchronous, active-high reset.
REQ-007 req_vld  input  1  ratio-change request valid.
REQ-008 req_ratio  input  NUM_DIV*DIV_WIDTH  new ratios; divider i in bits [i*DIV_WIDTH +: DIV_WIDTH].
REQ-009 req_rdy  output  1  sequencer can accept a request.
REQ-010 div_clk_align  input  NUM_DIV  per-divider alignment indication; 1 = last count of period or bypass.
REQ-011 div_ratio  output  NUM_DIV*DIV_WIDTH  registered ratios to the dividers.
REQ-012 div_aln_rst_n  output  1  active-low alignment reset to all dividers.
REQ-013 divider_go_pls  output  1  one-cycle restart pulse to all dividers.
REQ-014 seq_busy  output  1  high in every state except IDLE.
REQ-015 seq_done  output  1  one-cycle completion pulse.
REQ-016 aln_err  output  1  sticky alignment-timeout flag.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT_ALN, HOLD and GO, and all outputs SHALL be registered.
REQ-018 In IDLE, req_rdy SHALL be 1; in all other states it SHALL be 0, and req_vld SHALL be ignored.
REQ-019 When req_vld&req_rdy is high in cycle T, req_ratio SHALL be latched, aln_err SHALL be cleared, and the state SHALL be WAIT_ALN at T+1.
REQ-020 In WAIT_ALN, the first cycle A where all div_clk_align bits are 1 SHALL cause the following at A+1: div_ratio equals the latched value, div_aln_rst_n=0, state HOLD.
REQ-021 div_aln_rst_n SHALL be low for exactly ALN_HOLD consecutive cycles.
REQ-022 In the cycle after HOLD ends, the state SHALL be GO, with divider_go_pls=1 and div_aln_rst_n=1 for exactly one cycle.
REQ-023 In the cycle after GO, the state SHALL be IDLE, with seq_done=1 for one cycle and req_rdy=1.
REQ-024 div_ratio SHALL change only on HOLD entry, and it SHALL stay stable at all other times.
REQ-025 A ratio value of 0 or 1 SHALL be passed through unchanged, because the dividers treat it as bypass.
REQ-026 div_aln_rst_n and divider_go_pls SHALL never both be active in the same cycle.

Reset
REQ-027 When grst=1 at a rising edge, the following SHALL hold in the next cycle: state=IDLE, div_ratio has every field =1, div_aln_rst_n=1, divider_go_pls=0, seq_busy=0, seq_done=0, aln_err=0, req_rdy=1, and all internal counters =0.
REQ-028 Reset asserted mid-sequence SHALL abort it without emitting divider_go_pls or seq_done, and SHALL drive div_aln_rst_n=1 and div_ratio back to all-1.

Configuration
REQ-029 The macro RCG_DIV_SEQ_TIMEOUT_EN, when defined, SHALL compile in a 16-bit wait counter that is cleared on WAIT_ALN entry.
REQ-030 With RCG_DIV_SEQ_TIMEOUT_EN defined, if alignment has not occurred after TIMEOUT_CYC cycles in WAIT_ALN, the following SHALL happen in the next cycle: aln_err=1 (sticky until the next accepted request or reset), state HOLD, and div_ratio updated; the sequence SHALL then continue normally.
REQ-031 Without RCG_DIV_SEQ_TIMEOUT_EN, WAIT_ALN SHALL wait indefinitely, aln_err SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-032 Reset, then a request with ratios {2,4,8,3} and all div_clk_align=1 at T+1 -> at T+2 div_ratio={2,4,8,3} and div_aln_rst_n=0 for 4 cycles; go pulse at T+6; seq_done at T+7.
REQ-033 Assert div_clk_align bits one at a time, never all four together, for 50 cycles, then all together -> HOLD is entered only the cycle after all four are high, and div_ratio is unchanged before that.
REQ-034 Assert req_vld with a different ratio while in HOLD -> the request is ignored, req_rdy=0, and the first sequence completes with the original ratios.
REQ-035 Assert grst during HOLD -> div_aln_rst_n=1, div_ratio all 1, no divider_go_pls, and IDLE in the next cycle.
REQ-036 With RCG_DIV_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, hold div_clk_align=0 -> aln_err=1 and HOLD after 16 wait cycles; the next accepted request clears aln_err.
